// File: rtl/snn_pkg.sv
// Shared types and constant helpers for the spiking-neuron datapath blocks.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of three-synapse groups needed to cover nsyn synapses.
    function automatic int calc_ng(input int nsyn);
        return (nsyn + 2) / 3;
    endfunction

    // Largest unsigned value representable in w bits.
    function automatic int sat_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/csa_adder_4in.sv
// Four-operand unsigned adder: two 3:2 carry-save layers, then one carry-propagate add.
module csa_adder_4in #(
    parameter int p_input_width = 14
) (
    input  logic [p_input_width-1:0] a_i,
    input  logic [p_input_width-1:0] b_i,
    input  logic [p_input_width-1:0] c_i,
    input  logic [p_input_width-1:0] d_i,
    output logic [p_input_width+1:0] sum_o
);

    localparam int W = p_input_width;

    logic [W-1:0] s1;
    logic [W:0]   c1;
    logic [W:0]   s2;
    logic [W+1:0] c2;
    logic [W:0]   x2;
    logic [W:0]   z2;

    assign s1 = a_i ^ b_i ^ c_i;
    assign c1 = {((a_i & b_i) | (a_i & c_i) | (b_i & c_i)), 1'b0};

    assign x2 = {1'b0, s1};
    assign z2 = {1'b0, d_i};
    assign s2 = x2 ^ c1 ^ z2;
    assign c2 = {((x2 & c1) | (x2 & z2) | (c1 & z2)), 1'b0};

    assign sum_o = {1'b0, s2} + c2;

endmodule

// File: rtl/syn_accum_sched.sv
// Integrates spike-gated synaptic weights into a membrane potential by time-sharing
// one 4-input adder over three-synapse groups, then applies the firing threshold.
module syn_accum_sched
    import snn_pkg::*;
#(
    parameter int P_W    = 14,
    parameter int P_NSYN = 8,
    parameter int P_THR  = 1000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [P_NSYN-1:0]     i_spikes,
    input  logic [P_NSYN*P_W-1:0] i_weights,
    input  logic [P_W-1:0]        i_vmem,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [P_W-1:0]        o_vmem,
    output logic                  o_spike
);

    localparam int NG   = calc_ng(P_NSYN);
    localparam int NPAD = 3 * NG;
    localparam int GW   = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [P_W-1:0] SAT_MAX = P_W'(sat_max(P_W));
    localparam logic [P_W-1:0] THR     = P_W'(P_THR);

    state_e            state_q, state_d;
    logic [P_W-1:0]    w_q [NPAD];
    logic [P_W-1:0]    w_d [NPAD];
    logic [P_W-1:0]    w_in [NPAD];
    logic [NG-1:0]     mask_q, mask_d, mask_in;
    logic [P_W-1:0]    acc_q, acc_d;
    logic [P_W-1:0]    vmem_q, vmem_d;
    logic              spike_q, spike_d;
    logic              valid_q, valid_d;

    logic [NPAD-1:0]     spk_pad;
    logic [NPAD*P_W-1:0] wvec_pad;
    logic [GW-1:0]       cur;
    logic [P_W-1:0]      ga, gb, gc;
    logic [P_W+1:0]      sum;
    logic [P_W-1:0]      acc_sat;
    logic [P_W-1:0]      res_src;
    logic                enter_done;

    // Weights are gated by their spike bit at capture; synapses past P_NSYN pad to zero.
    always_comb begin
        spk_pad                    = '0;
        spk_pad[P_NSYN-1:0]        = i_spikes;
        wvec_pad                   = '0;
        wvec_pad[P_NSYN*P_W-1:0]   = i_weights;
        for (int k = 0; k < NPAD; k++) begin
            w_in[k] = spk_pad[k] ? wvec_pad[k*P_W +: P_W] : '0;
        end
        for (int g = 0; g < NG; g++) begin
            mask_in[g] = |spk_pad[3*g +: 3];
        end
    end

    // Find-first: the lowest remaining active group wins.
    always_comb begin
        cur = '0;
        for (int g = NG - 1; g >= 0; g--) begin
            if (mask_q[g]) cur = GW'(g);
        end
        ga = '0;
        gb = '0;
        gc = '0;
        for (int g = 0; g < NG; g++) begin
            if (cur == GW'(g)) begin
                ga = w_q[3*g];
                gb = w_q[3*g+1];
                gc = w_q[3*g+2];
            end
        end
    end

    csa_adder_4in #(
        .p_input_width(P_W)
    ) u_csa (
        .a_i  (ga),
        .b_i  (gb),
        .c_i  (gc),
        .d_i  (acc_q),
        .sum_o(sum)
    );

    assign acc_sat = (sum > {2'b00, SAT_MAX}) ? SAT_MAX : sum[P_W-1:0];

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        mask_d     = mask_q;
        acc_d      = acc_q;
        vmem_d     = vmem_q;
        spike_d    = spike_q;
        valid_d    = 1'b0;
        res_src    = acc_q;
        enter_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    w_d    = w_in;
                    acc_d  = i_vmem;
                    mask_d = mask_in;
                    if (|mask_in) begin
                        state_d = ST_ACC;
                    end else begin
                        state_d    = ST_DONE;
                        res_src    = i_vmem;
                        enter_done = 1'b1;
                    end
                end
            end
            ST_ACC: begin
                acc_d = acc_sat;
                for (int g = 0; g < NG; g++) begin
                    if (cur == GW'(g)) mask_d[g] = 1'b0;
                end
                if (mask_d == '0) begin
                    state_d    = ST_DONE;
                    res_src    = acc_sat;
                    enter_done = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The result is registered on the edge entering DONE so it is valid during DONE.
        if (enter_done) begin
            valid_d = 1'b1;
            spike_d = (res_src >= THR);
            vmem_d  = (res_src >= THR) ? '0 : res_src;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            acc_q   <= '0;
            vmem_q  <= '0;
            spike_q <= 1'b0;
            valid_q <= 1'b0;
            for (int k = 0; k < NPAD; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            acc_q   <= acc_d;
            vmem_q  <= vmem_d;
            spike_q <= spike_d;
            valid_q <= valid_d;
            for (int k = 0; k < NPAD; k++) begin
                w_q[k] <= w_d[k];
            end
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = valid_q;
    assign o_vmem  = vmem_q;
    assign o_spike = spike_q;

endmodule

// File: tb/tb_syn_accum_sched.sv
// Scoreboard bench for syn_accum_sched: directed requests push expected results,
// an independent monitor pops and checks them whenever o_valid is seen.
module tb_syn_accum_sched;

    localparam int W    = 14;
    localparam int NSYN = 8;

    typedef struct {
        logic [W-1:0] vmem;
        logic         spk;
        int           lat;
        int           acc_cyc;
        string        name;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [NSYN-1:0]   spikes;
    logic [NSYN*W-1:0] weights;
    logic [W-1:0]      vmem_in;
    logic              ready;
    logic              valid;
    logic [W-1:0]      vmem_out;
    logic              spike_out;

    exp_t         sb[$];
    int           compared = 0;
    int           mismatched = 0;
    int           cyc = 0;
    logic [W-1:0] held_v = '0;
    logic         held_s = 1'b0;

    syn_accum_sched #(
        .P_W   (W),
        .P_NSYN(NSYN),
        .P_THR (1000)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_spikes (spikes),
        .i_weights(weights),
        .i_vmem   (vmem_in),
        .o_ready  (ready),
        .o_valid  (valid),
        .o_vmem   (vmem_out),
        .o_spike  (spike_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every o_valid, otherwise checks outputs are held.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                check("ready_valid_exclusive", int'(ready), 0);
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_valid: got o_valid=1 at cycle %0d, required no result", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_vmem"}, int'(vmem_out), int'(e.vmem));
                    check({e.name, "_spike"}, int'(spike_out), int'(e.spk));
                    check({e.name, "_latency"}, cyc - e.acc_cyc, e.lat + 1);
                    held_v = e.vmem;
                    held_s = e.spk;
                end
            end else begin
                check("hold_vmem", int'(vmem_out), int'(held_v));
                check("hold_spike", int'(spike_out), int'(held_s));
            end
        end
    end

    task automatic set_all_w(input logic [W-1:0] v);
        for (int k = 0; k < NSYN; k++) weights[k*W +: W] = v;
    endtask

    task automatic set_w(input int k, input logic [W-1:0] v);
        weights[k*W +: W] = v;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = ready;
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL ready_timeout: got o_ready=0 after 50 cycles, required 1");
        end
    endtask

    // Drives one request for a single cycle and records the expected result.
    task automatic issue(input string name, input logic [NSYN-1:0] spk, input logic [W-1:0] vm,
                         input logic [W-1:0] ev, input logic es, input int a);
        bit ok;
        exp_t e;
        @(negedge clk);
        wait_ready(ok);
        if (ok) begin
            spikes  = spk;
            vmem_in = vm;
            start   = 1'b1;
            e.vmem = ev; e.spk = es; e.lat = a; e.acc_cyc = cyc; e.name = name;
            sb.push_back(e);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        rst_n   = 1'b0;
        start   = 1'b0;
        spikes  = '0;
        weights = '0;
        vmem_in = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_valid", int'(valid), 0);
        check("rst_vmem", int'(vmem_out), 0);
        check("rst_spike", int'(spike_out), 0);
        rst_n = 1'b1;

        set_all_w(14'd0);
        issue("no_spikes", 8'h00, 14'd100, 14'd100, 1'b0, 0);

        set_all_w(14'd10);
        issue("all_spikes_w10", 8'hFF, 14'd0, 14'd80, 1'b0, 3);

        set_all_w(14'd123);
        set_w(7, 14'd50);
        issue("only_spike7", 8'h80, 14'd20, 14'd70, 1'b0, 1);

        set_all_w(14'd500);
        set_w(0, 14'd10);
        issue("thr_exact", 8'h01, 14'd990, 14'd0, 1'b1, 1);

        set_all_w(14'd16383);
        issue("saturate", 8'hFF, 14'd16383, 14'd0, 1'b1, 3);

        set_all_w(14'd7);
        set_w(1, 14'd300);
        set_w(2, 14'd400);
        issue("group0_pair", 8'h06, 14'd200, 14'd900, 1'b0, 1);

        set_all_w(14'd900);
        set_w(3, 14'd400);
        set_w(4, 14'd500);
        issue("below_thr", 8'h18, 14'd99, 14'd999, 1'b0, 1);

        set_all_w(14'd9);
        set_w(0, 14'd1);
        set_w(3, 14'd2);
        set_w(6, 14'd4);
        issue("sparse_3grp", 8'h49, 14'd993, 14'd0, 1'b1, 3);

        // Start pulsed while busy must be ignored: only one result appears.
        set_all_w(14'd10);
        issue("busy_start", 8'hFF, 14'd5, 14'd85, 1'b0, 3);
        spikes  = 8'h00;
        vmem_in = 14'd777;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;

        // Reset during ACC aborts the request without a result.
        @(negedge clk);
        wait_ready(ok);
        if (ok) begin
            set_all_w(14'd10);
            spikes  = 8'hFF;
            vmem_in = 14'd300;
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            check("abort_ready", int'(ready), 1);
            check("abort_valid", int'(valid), 0);
            check("abort_vmem", int'(vmem_out), 0);
            check("abort_spike", int'(spike_out), 0);
            held_v = '0;
            held_s = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
        end

        set_all_w(14'd1);
        issue("after_abort", 8'h03, 14'd40, 14'd42, 1'b0, 1);

        for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL pending_results: got %0d outstanding, required 0", sb.size());
        end
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/syn_accum_sched.md
# syn_accum_sched

Sequencer that time-shares one 4-input carry-save adder (`csa_adder_4in`) to integrate a neuron's weighted synaptic input into its membrane potential. On a start request it captures the presynaptic spike vector, the synapse weights and the current membrane potential. It then folds three spike-gated weights plus the running accumulator per cycle through the adder, skipping groups with no spikes, and saturates the result. Finally it applies the firing threshold and returns the new potential and spike flag to the neuron update logic.

## Interface
- `P_W`, 14, weight / membrane-potential width (unsigned)
- `P_NSYN`, 8, synapses per neuron
- `P_THR`, 1000, firing threshold (compare `>=`)
- `i_clk`  in  1  clock, rising edge
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_start`  in  1  request; accepted only when `o_ready`=1
- `i_spikes`  in  P_NSYN  presynaptic spike vector, bit k gates weight k
- `i_weights`  in  P_NSYN*P_W  flattened weights, weight k at [k*P_W +: P_W]
- `i_vmem`  in  P_W  membrane potential before integration
- `o_ready`  out  1  idle, can accept `i_start`
- `o_valid`  out  1  one-cycle pulse, result valid
- `o_vmem`  out  P_W  new membrane potential (held until next result)
- `o_spike`  out  1  neuron fired (held with `o_vmem`)

## Operation
- Constant NG = ceil(P_NSYN/3). Group g covers synapses 3g, 3g+1 and 3g+2. Indices ≥ P_NSYN read as zero.
- Group g is active when any of its spike bits is set.
- States:
  - IDLE: `o_ready`=1. On `i_start`, register spikes, weights and `i_vmem` into the accumulator, and register the active-group mask. If the mask is nonzero go to ACC at the lowest active group, else go to DONE.
  - ACC: adder inputs are a/b/c = gated weights of the current group (weight if spike bit set, else 0) and d = accumulator. If the adder sum is > 2^P_W−1, the accumulator becomes 2^P_W−1; otherwise it becomes the sum. Advance to the next active group; after the last active group go to DONE.
  - DONE: spike = (acc >= P_THR). Register `o_vmem` = spike ? 0 : acc, register `o_spike`, pulse `o_valid` for one cycle, then go to IDLE.
- Adder output width is P_W+2. Worst case 4·(2^P_W−1) fits, so there is no wrap before saturation.
- `i_start` is ignored while not IDLE. Inputs are sampled only at accept.
- `o_ready` is low in ACC and DONE. `o_ready`=1 and `o_valid`=1 are never both high in the same cycle.

## Timing
- Reset values: state IDLE, `o_ready`=1, `o_valid`=0, `o_vmem`=0, `o_spike`=0, accumulator 0, masks 0.
- Accept edge is T. There is one ACC cycle per active group (A cycles, 0 ≤ A ≤ NG).
- `o_valid` is high during cycle T+A+1, i.e. latency A+1 cycles. With P_NSYN=8 the maximum latency is 4.
- `o_ready` returns high in the cycle after `o_valid`. Back-to-back accept is possible on that edge.
- Reset asserted mid-operation: immediate return to IDLE with all reset values. No `o_valid` is produced for the aborted request.
- `o_vmem`/`o_spike` change only on the `o_valid` cycle.

## Structure
- Shared package `snn_pkg` holds:
  - the state enum (IDLE, ACC, DONE);
  - the NG computation function;
  - the saturation-max constant function of P_W.
- One sub-module instance: `csa_adder_4in` with `p_input_width`=P_W. There is no other arithmetic adder in the block.
- Group selection is a priority find-first over the remaining active-group mask; the current group bit is cleared each ACC cycle.

## Test plan
All scenarios use the default parameters (P_W=14, P_NSYN=8, P_THR=1000).
- No spikes, `i_vmem`=100 -> `o_valid` 1 cycle after accept, `o_vmem`=100, `o_spike`=0, no ACC cycles.
- All 8 spikes, all weights 10, `i_vmem`=0 -> 3 ACC cycles, `o_valid` at T+4, `o_vmem`=80, `o_spike`=0.
- Only spike 7, w7=50, `i_vmem`=20 -> groups 0 and 1 skipped, `o_valid` at T+2, `o_vmem`=70.
- `i_vmem`=990, only spike 0 with w0=10 -> sum exactly 1000, `o_spike`=1, `o_vmem`=0.
- All weights 16383, all spikes, `i_vmem`=16383 -> accumulator saturates at 16383 every cycle, `o_spike`=1, `o_vmem`=0.
- `i_start` pulsed during ACC is ignored (one `o_valid` only). `i_rst_n` low during ACC -> `o_ready`=1, `o_vmem`=0, no `o_valid`.
